// File: rtl/count_controller.sv
// count_controller: four-digit BCD up/down counter with run/pause/clear control.
// Clocked by clk_50MHz; clk_slow, both buttons and dir_up are synchronised
// before use. Buttons are debounced for DEBOUNCE_CYCLES stable cycles.
// Optional build macro SATURATE_EN: the count stops at 9999/0000 and drops
// to PAUSE on the boundary tick instead of wrapping.

// Per-button synchroniser, debouncer and press detector.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_50MHz,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    // Accepted level flips only after DEBOUNCE_CYCLES consecutive cycles of
    // disagreement; press pulses once on an accepted 0->1 change.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            if (sync[1] != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync[1];
                    cnt   <= '0;
                    press <= sync[1];
                end else begin
                    cnt   <= cnt + 1'b1;
                    press <= 1'b0;
                end
            end else begin
                cnt   <= '0;
                press <= 1'b0;
            end
        end
    end
endmodule

module count_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk_50MHz,
    input  logic        reset,
    input  logic        clk_slow,
    input  logic        btn_run,
    input  logic        btn_clear,
    input  logic        dir_up,
    output logic [15:0] count_bcd,
    output logic [1:0]  state,
    output logic        running,
    output logic        wrap_pulse
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10} state_t;

    state_t      state_q, state_d;
    logic [15:0] count_d;
    logic        wrap_d;
    logic [16:0] step;
    logic [2:0]  slow_sync;
    logic [1:0]  dir_sync;
    logic [1:0]  press;   // [0] run, [1] clear
    logic        tick;

    // One debouncer per button.
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [1:0] (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .btn       ({btn_clear, btn_run}),
        .press     (press)
    );

    // Per-digit BCD increment/decrement; bit 16 is the carry/borrow out.
    function automatic logic [16:0] bcd_step(input logic [15:0] v, input logic up);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (up) begin
                    if (v[i*4 +: 4] >= 4'd9) r[i*4 +: 4] = 4'd0;
                    else begin
                        r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (v[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'd9;
                    else begin
                        r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return {c, r};
    endfunction

    // Synchronise clk_slow (plus one edge-detect stage) and dir_up.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            slow_sync <= '0;
            dir_sync  <= '0;
        end else begin
            slow_sync <= {slow_sync[1:0], clk_slow};
            dir_sync  <= {dir_sync[0], dir_up};
        end
    end

    assign tick = slow_sync[1] & ~slow_sync[2];

    // Next state / next count. Clear beats everything, including a tick;
    // a tick in RUN is applied before a run press moves the FSM on.
    always_comb begin
        state_d = state_q;
        count_d = count_bcd;
        wrap_d  = 1'b0;
        step    = bcd_step(count_bcd, dir_sync[1]);
        if (press[1]) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            if (state_q == RUN && tick) begin
                wrap_d = step[16];
`ifdef SATURATE_EN
                if (step[16]) state_d = PAUSE;
                else          count_d = step[15:0];
`else
                count_d = step[15:0];
`endif
            end
            if (press[0]) begin
                case (state_q)
                    IDLE:    state_d = RUN;
                    RUN:     state_d = PAUSE;
                    PAUSE:   state_d = RUN;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // State, count and wrap pulse registers.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_bcd  <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_bcd  <= count_d;
            wrap_pulse <= wrap_d;
        end
    end

    assign state   = state_q;
    assign running = (state_q == RUN);
endmodule

// File: tb/tb_count_controller.sv
// Self-checking bench for count_controller with DEBOUNCE_CYCLES = 4.
// Reference model keeps the count as a plain integer 0..9999 and the
// controller mode as 0/1/2 (idle/run/pause).
module tb_count_controller;
    logic        clk_50MHz = 1'b0;
    logic        reset, clk_slow, btn_run, btn_clear, dir_up;
    logic [15:0] count_bcd;
    logic [1:0]  state;
    logic        running, wrap_pulse;

    int checks = 0;
    int errors = 0;
    int m_cnt  = 0;
    int m_st   = 0;
    bit m_wrap = 0;

    always #5 clk_50MHz = ~clk_50MHz;

    count_controller #(.DEBOUNCE_CYCLES(4)) dut (
        .clk_50MHz  (clk_50MHz),
        .reset      (reset),
        .clk_slow   (clk_slow),
        .btn_run    (btn_run),
        .btn_clear  (btn_clear),
        .dir_up     (dir_up),
        .count_bcd  (count_bcd),
        .state      (state),
        .running    (running),
        .wrap_pulse (wrap_pulse)
    );

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Model of one slow-clock tick.
    task automatic model_tick(input bit up);
        m_wrap = 0;
        if (m_st == 1) begin
            if (up) begin
                if (m_cnt == 9999) begin
                    m_wrap = 1;
`ifdef SATURATE_EN
                    m_st = 2;
`else
                    m_cnt = 0;
`endif
                end else m_cnt = m_cnt + 1;
            end else begin
                if (m_cnt == 0) begin
                    m_wrap = 1;
`ifdef SATURATE_EN
                    m_st = 2;
`else
                    m_cnt = 9999;
`endif
                end else m_cnt = m_cnt - 1;
            end
        end
    endtask

    // One clk_slow period; the count must change on the 3rd edge, not earlier.
    task automatic do_tick(input bit up);
        logic [15:0] old;
        old = to_bcd(m_cnt);
        dir_up = up;
        clk_slow = 1'b1;
        model_tick(up);
        repeat (2) @(negedge clk_50MHz);
        checks++;
        if (count_bcd !== old) begin
            errors++;
            $display("FAIL tick_early: got %h expected %h", count_bcd, old);
        end
        @(negedge clk_50MHz);
        checks++;
        if (count_bcd !== to_bcd(m_cnt)) begin
            errors++;
            $display("FAIL tick_count: got %h expected %h", count_bcd, to_bcd(m_cnt));
        end
        checks++;
        if (wrap_pulse !== m_wrap) begin
            errors++;
            $display("FAIL tick_wrap: got %b expected %b", wrap_pulse, m_wrap);
        end
        checks++;
        if (state !== 2'(m_st) || running !== (m_st == 1)) begin
            errors++;
            $display("FAIL tick_state: got %b/%b expected %0d", state, running, m_st);
        end
        clk_slow = 1'b0;
        @(negedge clk_50MHz);
        checks++;
        if (wrap_pulse !== 1'b0) begin
            errors++;
            $display("FAIL wrap_width: got %b expected 0", wrap_pulse);
        end
        repeat (2) @(negedge clk_50MHz);
    endtask

    // Hold button(s) well past the debounce window, release, check result.
    task automatic do_press(input bit run, input bit clr);
        btn_run = run;
        btn_clear = clr;
        repeat (10) @(negedge clk_50MHz);
        btn_run = 0;
        btn_clear = 0;
        repeat (10) @(negedge clk_50MHz);
        if (clr) begin
            m_st = 0;
            m_cnt = 0;
        end else if (run) m_st = (m_st == 1) ? 2 : 1;
        checks++;
        if (state !== 2'(m_st) || running !== (m_st == 1)) begin
            errors++;
            $display("FAIL press_state: got %b/%b expected %0d", state, running, m_st);
        end
        checks++;
        if (count_bcd !== to_bcd(m_cnt)) begin
            errors++;
            $display("FAIL press_count: got %h expected %h", count_bcd, to_bcd(m_cnt));
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_50MHz);
        checks++;
        if (count_bcd !== 16'h0000 || state !== 2'b00 || running !== 1'b0 || wrap_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got %h/%b/%b/%b expected 0000/00/0/0",
                     count_bcd, state, running, wrap_pulse);
        end
        reset = 0;
        repeat (3) @(negedge clk_50MHz);
        checks++;
        if (state !== 2'b00 || count_bcd !== 16'h0000) begin
            errors++;
            $display("FAIL after_release: got %b/%h expected 00/0000", state, count_bcd);
        end
    endtask

    task automatic test_first_count();
        do_press(1, 0);
        repeat (3) do_tick(1);
        checks++;
        if (count_bcd !== 16'h0003 || state !== 2'b01) begin
            errors++;
            $display("FAIL first_count: got %h/%b expected 0003/01", count_bcd, state);
        end
    endtask

    task automatic test_wrap();
        do_press(0, 1);
        do_press(1, 0);
        repeat (999) do_tick(1);
        checks++;
        if (count_bcd !== 16'h0999) begin
            errors++;
            $display("FAIL preload_0999: got %h expected 0999", count_bcd);
        end
        do_tick(1);
        checks++;
        if (count_bcd !== 16'h1000) begin
            errors++;
            $display("FAIL carry_1000: got %h expected 1000", count_bcd);
        end
        do_press(0, 1);
        do_press(1, 0);
        do_tick(0);   // down from 0000: wrap or saturate
        do_tick(1);   // back up through 9999 (ignored if paused)
    endtask

    task automatic test_bounce();
        do_press(0, 1);
        do_press(1, 0);
        for (int i = 0; i < 5; i++) begin
            btn_run = 1;
            repeat (2) @(negedge clk_50MHz);
            btn_run = 0;
            repeat (2) @(negedge clk_50MHz);
        end
        repeat (4) @(negedge clk_50MHz);
        checks++;
        if (state !== 2'(m_st)) begin
            errors++;
            $display("FAIL bounce_ignored: got %b expected %0d", state, m_st);
        end
        btn_run = 1;
        repeat (6) @(negedge clk_50MHz);
        btn_run = 0;
        repeat (10) @(negedge clk_50MHz);
        m_st = 2;
        checks++;
        if (state !== 2'(m_st)) begin
            errors++;
            $display("FAIL held_one_press: got %b expected %0d", state, m_st);
        end
    endtask

    task automatic test_simultaneous();
        do_press(0, 1);
        do_press(1, 0);
        repeat (42) do_tick(1);
        checks++;
        if (count_bcd !== 16'h0042) begin
            errors++;
            $display("FAIL preload_0042: got %h expected 0042", count_bcd);
        end
        do_press(1, 1);
        do_press(1, 0);
        do_tick(1);
        do_press(1, 0);
        repeat (2) do_tick(1);
        do_tick(0);
    endtask

    // Press pulse and tick aligned so both hit the FSM on the same edge.
    task automatic test_coincide();
        do_press(0, 1);
        do_press(1, 0);
        repeat (5) do_tick(1);
        btn_run = 1;
        repeat (4) @(negedge clk_50MHz);
        dir_up = 1;
        clk_slow = 1;
        repeat (4) @(negedge clk_50MHz);
        btn_run = 0;
        clk_slow = 0;
        repeat (10) @(negedge clk_50MHz);
        m_cnt = m_cnt + 1;
        m_st = 2;
        checks++;
        if (count_bcd !== to_bcd(m_cnt) || state !== 2'b10) begin
            errors++;
            $display("FAIL tick_with_pause: got %h/%b expected %h/10", count_bcd, state, to_bcd(m_cnt));
        end
        do_press(1, 0);
        btn_clear = 1;
        repeat (4) @(negedge clk_50MHz);
        clk_slow = 1;
        repeat (4) @(negedge clk_50MHz);
        btn_clear = 0;
        clk_slow = 0;
        repeat (10) @(negedge clk_50MHz);
        m_cnt = 0;
        m_st = 0;
        checks++;
        if (count_bcd !== 16'h0000 || state !== 2'b00) begin
            errors++;
            $display("FAIL tick_with_clear: got %h/%b expected 0000/00", count_bcd, state);
        end
    endtask

    task automatic test_async_reset();
        do_press(1, 0);
        repeat (1234) do_tick(1);
        checks++;
        if (count_bcd !== 16'h1234 || state !== 2'b01) begin
            errors++;
            $display("FAIL preload_1234: got %h/%b expected 1234/01", count_bcd, state);
        end
        @(posedge clk_50MHz);
        #2 reset = 1;
        #1;
        checks++;
        if (count_bcd !== 16'h0000 || state !== 2'b00 || running !== 1'b0 || wrap_pulse !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got %h/%b/%b/%b expected 0000/00/0/0",
                     count_bcd, state, running, wrap_pulse);
        end
        btn_run = 1;
        @(negedge clk_50MHz);
        reset = 0;
        m_cnt = 0;
        m_st = 0;
        repeat (4) @(negedge clk_50MHz);
        checks++;
        if (state !== 2'b00) begin
            errors++;
            $display("FAIL early_press_after_reset: got %b expected 00", state);
        end
        repeat (10) @(negedge clk_50MHz);
        btn_run = 0;
        m_st = 1;
        checks++;
        if (state !== 2'b01) begin
            errors++;
            $display("FAIL press_after_reset: got %b expected 01", state);
        end
        repeat (10) @(negedge clk_50MHz);
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 6)      do_tick(bit'($urandom_range(0, 1)));
            else if (r <= 8) do_press(1, 0);
            else             do_press(0, 1);
        end
    endtask

    initial begin
        reset = 1;
        clk_slow = 0;
        btn_run = 0;
        btn_clear = 0;
        dir_up = 1;
        test_reset();
        test_first_count();
        test_wrap();
        test_bounce();
        test_simultaneous();
        test_coincide();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/count_controller.md
COUNT_CONTROLLER -- requirements
Module: count_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive stable clk_50MHz cycles (20 ms) a button needs before its level is accepted.
REQ-002 clk_50MHz  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 clk_slow  input  1  divided clock from the speed-selectable divider, treated as an asynchronous data input.
REQ-005 btn_run  input  1  raw active-high pushbutton, asynchronous; each accepted press toggles run/pause.
REQ-006 btn_clear  input  1  raw active-high pushbutton, asynchronous; an accepted press clears the count and returns to IDLE.
REQ-007 dir_up  input  1  count direction, 1 = up, 0 = down; synchronised internally, with a 2-flop latency.
REQ-008 count_bcd  output  16  four BCD digits, [15:12] thousands down to [3:0] units, range 0000-9999.
REQ-009 state  output  2  FSM state: IDLE=00, RUN=01, PAUSE=10; 11 is never driven.
REQ-010 running  output  1  high exactly when state = RUN.
REQ-011 wrap_pulse  output  1  one-cycle pulse on a count boundary event (REQ-020, REQ-026).

Function
REQ-012 clk_slow, btn_run, btn_clear and dir_up shall each pass through a 2-flop synchroniser before any use.
REQ-013 Tick: a rising edge of synchronised clk_slow shall produce a one-cycle internal tick, with the count updating on the 3rd clk_50MHz rising edge after clk_slow rises.
REQ-014 Debounce: each button shall have its own counter; the accepted level shall change only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles, and any bounce shall restart the count.
REQ-015 Press: an accepted 0->1 transition shall produce a one-cycle press pulse; a held button shall produce no further pulses.
REQ-016 FSM transitions: IDLE --run press--> RUN; RUN --run press--> PAUSE; PAUSE --run press--> RUN; any state --clear press--> IDLE.
REQ-017 Simultaneous run and clear press in one cycle: clear shall win, giving IDLE with count 0000.
REQ-018 Entering IDLE shall set count_bcd to 0000 on the same edge.
REQ-019 Counting: the count shall change by exactly one BCD step per tick, only in RUN; ticks in IDLE or PAUSE shall be ignored, and PAUSE shall hold the count.
REQ-020 Wrap (default build): up from 9999 shall give 0000, and down from 0000 shall give 9999, with wrap_pulse high for the same cycle the count updates.
REQ-021 BCD arithmetic shall be per-digit: a digit at 9 going up becomes 0 with carry; a digit at 0 going down becomes 9 with borrow; no digit shall ever exceed 9.
REQ-022 A tick coinciding with a run press that leaves RUN shall still be applied: the count updates, then the FSM enters PAUSE.
REQ-023 A tick coinciding with a clear press shall be discarded, leaving count 0000.

Reset
REQ-024 While reset is high: count_bcd = 0000, state = IDLE, running = 0, wrap_pulse = 0, all synchronisers and debounce counters cleared, accepted button levels = 0.
REQ-025 Reset asserted mid-count shall take effect immediately, without waiting for a clock edge; after release, no press is recognised until a button has been stable high for DEBOUNCE_CYCLES.

Configuration
REQ-026 When SATURATE_EN is defined, the count shall stop at 9999 (up) or 0000 (down) instead of wrapping. On the tick that would cross the boundary, the count is held, wrap_pulse pulses and the FSM goes RUN->PAUSE. Ticks in PAUSE remain ignored. When SATURATE_EN is undefined, REQ-020 applies.

Verification (DEBOUNCE_CYCLES = 4)
REQ-027 Reset, then btn_run high for 10 cycles, then dir_up=1 and 3 clk_slow rising edges -> state 01, count_bcd 0x0003, each update 3 cycles after its clk_slow edge.
REQ-028 Preload to 0x0999 by counting up, one more tick -> 0x1000; at 0x9999 plus one tick -> 0x0000 with wrap_pulse high for 1 cycle (SATURATE_EN off).
REQ-029 Start RUN from 0x0000, dir_up=0, one tick -> 0x9999 and wrap_pulse; with SATURATE_EN on -> count stays 0x0000, wrap_pulse, state 10.
REQ-030 btn_run toggling every 2 cycles for 20 cycles -> no state change; then held for 6 cycles -> exactly one transition.
REQ-031 btn_run and btn_clear pressed on the same cycle while in RUN at 0x0042 -> state 00, count 0x0000; ticks in PAUSE leave count unchanged.
REQ-032 reset pulsed asynchronously between clock edges while in RUN at 0x1234 -> outputs reach their reset values before the next edge.
